// File: rtl/pad_debounce3.sv
// Three-channel pad synchroniser and debouncer with press/release pulses.
// Optional latched on/off levels when PAD_DEBOUNCE_TOGGLE_EN is defined.
module pad_debounce3 #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] pad_raw,
    output logic [2:0] pad_level,
    output logic [2:0] pad_press,
    output logic [2:0] pad_release,
    output logic       any_press,
    output logic       busy
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 1 ||
            longint'(DEBOUNCE_CYCLES) > ((longint'(1) << CNT_W) - 1)) begin : g_param_check
            $error("pad_debounce3: DEBOUNCE_CYCLES must be in 1 .. 2**CNT_W-1");
        end
    endgenerate

    logic [2:0]            s1;
    logic [2:0]            s2;
    logic [2:0]            stable;
    logic [2:0]            press_q;
    logic [2:0]            release_q;
    logic [2:0][CNT_W-1:0] cnt;
`ifdef PAD_DEBOUNCE_TOGGLE_EN
    logic [2:0]            toggle_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= '0;
            s2        <= '0;
            stable    <= '0;
            press_q   <= '0;
            release_q <= '0;
            cnt       <= '0;
`ifdef PAD_DEBOUNCE_TOGGLE_EN
            toggle_q  <= '0;
`endif
        end else begin
            s1        <= pad_raw;
            s2        <= s1;
            press_q   <= '0;
            release_q <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == TERM) begin
                    // Terminal count: commit the new level and fire the matching pulse.
                    stable[i]    <= s2[i];
                    cnt[i]       <= '0;
                    press_q[i]   <= s2[i];
                    release_q[i] <= ~s2[i];
`ifdef PAD_DEBOUNCE_TOGGLE_EN
                    if (s2[i]) begin
                        toggle_q[i] <= ~toggle_q[i];
                    end
`endif
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef PAD_DEBOUNCE_TOGGLE_EN
    assign pad_level = toggle_q;
`else
    assign pad_level = stable;
`endif
    assign pad_press   = press_q;
    assign pad_release = release_q;
    assign any_press   = |press_q;
    assign busy        = |cnt;

endmodule
